// File: rtl/xclk_word_scheduler.sv
// xclk_word_scheduler: arbitrates NUM_REQ requesters onto one shared crossing word and holds it steady.
// Latency: the bus changes 2 clk after req is raised; ack pulses HOLD_CYCLES clk after the bus change.
// Backpressure: one transfer at a time; requesters hold req/req_data until their ack pulse.
// Build option: define XCLK_SCHED_FIXED_PRI_EN for fixed priority (lowest index wins) instead of round-robin.
module xclk_word_scheduler #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 8,
    localparam int TAG_W      = $clog2(NUM_REQ),
    localparam int BUS_W      = 1 + TAG_W + DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          busy,
    output logic [BUS_W-1:0]              xfer_bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    // HOLD lasts HOLD_CYCLES-1 cycles; together with the LOAD edge the word is stable HOLD_CYCLES clocks.
    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 2);
    localparam logic [TAG_W-1:0] LAST_IDX  = TAG_W'(NUM_REQ - 1);

    state_t                  state;
    logic [TAG_W-1:0]        winner;
    logic                    toggle;
    logic [7:0]              hold_cnt;

    logic [TAG_W-1:0]        pick;
    logic                    pick_vld;
    logic [DATA_WIDTH-1:0]   sel_data;

`ifdef XCLK_SCHED_FIXED_PRI_EN
    // Fixed priority: scan downward so the lowest asserted index is the last one written.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick     = TAG_W'(i);
                pick_vld = 1'b1;
            end
        end
    end
`else
    logic [TAG_W-1:0]        rr_ptr;

    // Round-robin: first asserted index at or after rr_ptr, wrapping past NUM_REQ-1 back to 0.
    // Offsets are scanned from the far end so the nearest asserted index wins.
    always_comb begin
        logic [TAG_W:0] idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + (TAG_W+1)'(i);
            if (idx >= (TAG_W+1)'(NUM_REQ)) begin
                idx = idx - (TAG_W+1)'(NUM_REQ);
            end
            if (req[idx[TAG_W-1:0]]) begin
                pick     = idx[TAG_W-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Pointer moves past the requester just served, so every requester gets a turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (state == ST_ACK) begin
            rr_ptr <= (winner == LAST_IDX) ? '0 : winner + TAG_W'(1);
        end
    end
`endif

    // Payload mux for the latched winner; only consumed at the LOAD edge.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == TAG_W'(i)) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Transfer sequencer: grant, drive the word once, hold it, then pulse ack for the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            winner   <= '0;
            toggle   <= 1'b0;
            hold_cnt <= '0;
            xfer_bus <= '0;
            ack      <= '0;
            busy     <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        winner <= pick;
                        busy   <= 1'b1;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // The toggle flip makes back-to-back identical words still look new downstream.
                    xfer_bus <= {~toggle, winner, sel_data};
                    toggle   <= ~toggle;
                    hold_cnt <= '0;
                    state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= ST_ACK;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                ST_ACK: begin
                    ack   <= NUM_REQ'(1) << winner;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xclk_word_scheduler.sv
// tb_xclk_word_scheduler: checks grant order, bus word/toggle, hold time and ack timing.
// Latency: bus expected 2 clk after req launch, ack HOLD_CYCLES clk after each bus change.
// Backpressure: requesters model holding req until ack, dropping it on the ack cycle.
`timescale 1ns/1ps
module tb_xclk_word_scheduler;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int HC = 8;
    localparam int TW = 2;
    localparam int BW = 1 + TW + DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     ack;
    logic              busy;
    logic [BW-1:0]     xfer_bus;

    always #5 clk = ~clk;

    xclk_word_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .HOLD_CYCLES(HC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_data(req_data),
        .ack     (ack),
        .busy    (busy),
        .xfer_bus(xfer_bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every bus change pops one expected word; every ack closes it.
    logic [BW-1:0] prev_bus = '0;
    logic          exp_tog  = 1'b0;
    logic          inflight = 1'b0;
    logic [TW-1:0] fl_tag   = '0;
    int            chg_cyc  = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_bus = '0;
                exp_tog  = 1'b0;
                inflight = 1'b0;
            end else begin
                if (xfer_bus !== prev_bus) begin
                    chk("bus_while_inflight", 32'(inflight), 32'd0);
                    chk("bus_expected", 32'(sb_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0) begin
                        e       = sb_q.pop_front();
                        exp_tog = ~exp_tog;
                        chk("bus_word", 32'(xfer_bus), 32'({exp_tog, e.tag, e.data}));
                        fl_tag  = e.tag;
                    end
                    inflight = 1'b1;
                    chg_cyc  = cyc;
                    prev_bus = xfer_bus;
                end
                if (ack !== '0) begin
                    chk("ack_inflight", 32'(inflight), 32'd1);
                    chk("ack_onehot", 32'(ack), 32'd1 << fl_tag);
                    chk("ack_latency", 32'(cyc - chg_cyc), 32'(HC));
                    inflight = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NR-1:0] r, input logic [NR*DW-1:0] d, input logic [TW-1:0] tag);
        exp_t e;
        req      = r;
        req_data = d;
        e.tag    = tag;
        e.data   = d[tag*DW +: DW];
        sb_q.push_back(e);
    endtask

    // Push an extra expected grant without touching the driven inputs.
    task automatic expect_grant(input logic [NR*DW-1:0] d, input logic [TW-1:0] tag);
        exp_t e;
        e.tag  = tag;
        e.data = d[tag*DW +: DW];
        sb_q.push_back(e);
    endtask

    task automatic wait_ack(input logic [NR-1:0] drop_mask, input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ack == '0 && t < 200);
        chk(name, 32'(ack != '0), 32'd1);
        req = req & ~drop_mask;
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_bus"},  32'(xfer_bus), 32'd0);
        chk({name, "_busy"}, 32'(busy),     32'd0);
        chk({name, "_ack"},  32'(ack),      32'd0);
    endtask

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*DW-1:0] data;
        logic [TW-1:0]    tag_rr;
        logic [TW-1:0]    tag_fp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [BW-1:0]    b1, b2;
        logic [NR*DW-1:0] d;
        logic [TW-1:0]    tg;

        // Sequence follows test 1, which leaves the round-robin pointer at 3.
        tbl[0] = '{4'b0011, 32'h44332211, 2'd0, 2'd0};
        tbl[1] = '{4'b1011, 32'h88776655, 2'd1, 2'd0};
        tbl[2] = '{4'b1011, 32'hCCBBAA99, 2'd3, 2'd0};
        tbl[3] = '{4'b1010, 32'h0F1E2D3C, 2'd1, 2'd1};
        tbl[4] = '{4'b0001, 32'hDEADBEEF, 2'd0, 2'd0};
        tbl[5] = '{4'b1000, 32'h12345678, 2'd3, 2'd3};
        tbl[6] = '{4'b1111, 32'hF0E1D2C3, 2'd0, 2'd0};

        // Reset state
        #12;
        check_reset_state("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: single requester 2, exact latency and hold window
        drive(4'b0100, 32'h00A50000, 2'd2);
        tick();
        chk("t1_busy_load", 32'(busy), 32'd1);
        chk("t1_bus_not_yet", 32'(xfer_bus), 32'd0);
        tick();
        chk("t1_bus", 32'(xfer_bus), 32'({1'b1, 2'd2, 8'hA5}));
        for (int i = 0; i < HC - 1; i++) begin
            tick();
            chk("t1_bus_stable", 32'(xfer_bus), 32'({1'b1, 2'd2, 8'hA5}));
            chk("t1_no_early_ack", 32'(ack), 32'd0);
        end
        tick();
        chk("t1_ack", 32'(ack), 32'b0100);
        chk("t1_busy_done", 32'(busy), 32'd0);
        req = '0;
        tick();
        chk("t1_ack_pulse", 32'(ack), 32'd0);

        // Table: one transfer per vector
        for (int i = 0; i < 7; i++) begin
            tick();
`ifdef XCLK_SCHED_FIXED_PRI_EN
            tg = tbl[i].tag_fp;
`else
            tg = tbl[i].tag_rr;
`endif
            drive(tbl[i].req, tbl[i].data, tg);
            wait_ack(4'b1111, "tbl_ack_seen");
            chk("tbl_ack_idx", 32'(ack), 32'd1 << tg);
            d = tbl[i].data;
            chk("tbl_bus_data", 32'(xfer_bus[DW-1:0]), 32'(d[tg*DW +: DW]));
        end

        // Test 3: identical word twice, toggle must differ
        tick();
        drive(4'b0010, 32'h00003C00, 2'd1);
        wait_ack(4'b0010, "t3_ack1");
        b1 = xfer_bus;
        tick();
        drive(4'b0010, 32'h00003C00, 2'd1);
        wait_ack(4'b0010, "t3_ack2");
        b2 = xfer_bus;
        chk("t3_toggle_diff", 32'(b1[BW-1] ^ b2[BW-1]), 32'd1);
        chk("t3_data1", 32'(b1[DW-1:0]), 32'h3C);
        chk("t3_data2", 32'(b2[DW-1:0]), 32'h3C);

        // Test 6: req and data change after LOAD are ignored
        tick();
        drive(4'b0001, 32'h00000077, 2'd0);
        tick();
        tick();
        req      = 4'b0000;
        req_data = 32'h000000FF;
        tick();
        tick();
        chk("t6_bus_kept", 32'(xfer_bus[DW-1:0]), 32'h77);
        wait_ack(4'b0000, "t6_ack_seen");
        chk("t6_ack_idx", 32'(ack), 32'b0001);
        chk("t6_bus_after", 32'(xfer_bus[DW-1:0]), 32'h77);

        // Test 4: reset during the 3rd HOLD cycle, pending request restarts
        tick();
        drive(4'b0100, 32'h005A0000, 2'd2);
        tick();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_state("t4_abort");
        expect_grant(32'h005A0000, 2'd2);
        tick();
        chk("t4_no_ack_rst", 32'(ack), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t4_busy_restart", 32'(busy), 32'd1);
        chk("t4_bus_idle", 32'(xfer_bus), 32'd0);
        tick();
        chk("t4_bus_restart", 32'(xfer_bus), 32'({1'b1, 2'd2, 8'h5A}));
        wait_ack(4'b0100, "t4_ack_seen");
        chk("t4_ack_idx", 32'(ack), 32'b0100);

        // Fresh reset before the continuous-request sequence
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_state("reset2");
        tick();
        rst_n = 1'b1;
        tick();

`ifdef XCLK_SCHED_FIXED_PRI_EN
        // Test 5: fixed priority with req 1010 held; 3 served only after 1 drops
        drive(4'b1010, 32'h40302010, 2'd1);
        expect_grant(32'h40302010, 2'd1);
        expect_grant(32'h40302010, 2'd1);
        expect_grant(32'h40302010, 2'd3);
        wait_ack(4'b0000, "t5_ack_a");
        chk("t5_idx_a", 32'(ack), 32'b0010);
        wait_ack(4'b0000, "t5_ack_b");
        chk("t5_idx_b", 32'(ack), 32'b0010);
        wait_ack(4'b0010, "t5_ack_c");
        chk("t5_idx_c", 32'(ack), 32'b0010);
        wait_ack(4'b1000, "t5_ack_d");
        chk("t5_idx_d", 32'(ack), 32'b1000);
`else
        // Test 2: round-robin with all requests held continuously
        drive(4'b1111, 32'h40302010, 2'd0);
        expect_grant(32'h40302010, 2'd1);
        expect_grant(32'h40302010, 2'd2);
        expect_grant(32'h40302010, 2'd3);
        expect_grant(32'h40302010, 2'd0);
        for (int k = 0; k < 5; k++) begin
            wait_ack((k == 4) ? 4'b1111 : 4'b0000, "t2_ack_seen");
            chk("t2_ack_order", 32'(ack), 32'd1 << (k % 4));
            chk("t2_tag_match", 32'(xfer_bus[DW +: TW]), 32'(k % 4));
        end
`endif

        // Drain and confirm nothing is left outstanding
        for (int i = 0; i < HC + 4; i++) tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("none_inflight", 32'(inflight), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
